// File: rtl/mock_alu_bypass_register_file_if.sv
// ---------------------------------------------------------------------------------------------
// mock_alu_bypass_register_file_if
// Bus bundle for the ALU-bypass register file.
//   io_read_address / io_read_value   : NUM_READ flattened read ports (data registered)
//   io_write_*                        : NUM_WRITE flattened byte-masked write ports
//   io_cmd_*                          : ALU command (valid/ready, op, sources, dest, byte mask)
//   io_busy / io_collisions           : status outputs
// master drives commands/writes; slave is the register file.
// ---------------------------------------------------------------------------------------------
interface mock_alu_bypass_register_file_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned NUM_READ   = 4,
   parameter int unsigned NUM_WRITE  = 2
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [NUM_READ*AW-1:0]          io_read_address;
   logic [NUM_READ*DATA_WIDTH-1:0]  io_read_value;
   logic [NUM_WRITE-1:0]            io_write_valid;
   logic [NUM_WRITE*AW-1:0]         io_write_address;
   logic [NUM_WRITE*DATA_WIDTH-1:0] io_write_value;
   logic [NUM_WRITE*NB-1:0]         io_write_byteMask;
   logic                            io_cmd_valid;
   logic                            io_cmd_ready;
   logic [2:0]                      io_cmd_op;
   logic [AW-1:0]                   io_cmd_srcA;
   logic [AW-1:0]                   io_cmd_srcB;
   logic [AW-1:0]                   io_cmd_dst;
   logic [NB-1:0]                   io_cmd_byteMask;
   logic                            io_busy;
   logic [15:0]                     io_collisions;

   modport master (
      output io_read_address, io_write_valid, io_write_address, io_write_value,
             io_write_byteMask, io_cmd_valid, io_cmd_op, io_cmd_srcA, io_cmd_srcB,
             io_cmd_dst, io_cmd_byteMask,
      input  io_read_value, io_cmd_ready, io_busy, io_collisions
   );

   modport slave (
      input  io_read_address, io_write_valid, io_write_address, io_write_value,
             io_write_byteMask, io_cmd_valid, io_cmd_op, io_cmd_srcA, io_cmd_srcB,
             io_cmd_dst, io_cmd_byteMask,
      output io_read_value, io_cmd_ready, io_busy, io_collisions
   );
endinterface

// File: rtl/mock_alu_bypass_register_file.sv
// ---------------------------------------------------------------------------------------------
// mock_alu_bypass_register_file
// Multi-ported byte-masked register file with an attached pipelined ALU.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (clears pipeline, read data, collision count)
//   bus   : slave side of mock_alu_bypass_register_file_if (read/write ports, ALU command,
//           busy, collision counter)
// Reads and ALU operand fetches see every write committing on the same edge. Write priority
// per byte: ALU writeback > highest-index external port > lower ports.
// ---------------------------------------------------------------------------------------------
module mock_alu_bypass_register_file #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned NUM_READ    = 4,
   parameter int unsigned NUM_WRITE   = 2,
   parameter int unsigned ALU_LATENCY = 2
) (
   input logic                            clock,
   input logic                            reset,
   mock_alu_bypass_register_file_if.slave bus
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned NB   = DATA_WIDTH / 8;
   localparam int unsigned SHW  = $clog2(DATA_WIDTH);
   localparam int unsigned NSRC = NUM_WRITE + 1;  // external ports, then ALU writeback last
   localparam int unsigned NLK  = NUM_READ + 2;   // read ports, then ALU operands A and B

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [ALU_LATENCY-1:0] r_valid;
   logic [AW-1:0]          r_dst  [ALU_LATENCY];
   logic [NB-1:0]          r_mask [ALU_LATENCY];
   logic [DATA_WIDTH-1:0]  r_res  [ALU_LATENCY];

   logic [NUM_READ*DATA_WIDTH-1:0] r_read_value;
   logic [15:0]                    r_collisions;

   logic                  w_src_v [NSRC];
   logic [AW-1:0]         w_src_a [NSRC];
   logic [DATA_WIDTH-1:0] w_src_d [NSRC];
   logic [NB-1:0]         w_src_m [NSRC];
   logic [AW-1:0]         w_lk_a  [NLK];
   logic [DATA_WIDTH-1:0] w_lk_d  [NLK];
   logic [DATA_WIDTH-1:0] w_op_a;
   logic [DATA_WIDTH-1:0] w_op_b;
   logic [DATA_WIDTH-1:0] w_alu;
   logic                  w_collide;
   logic                  w_ready;
   logic                  w_accept;

   function automatic logic f_in_range(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   // Every write that commits on the coming edge; out-of-range addresses are dropped here.
   always_comb begin
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
         w_src_a[w] = bus.io_write_address[w*AW +: AW];
         w_src_d[w] = bus.io_write_value[w*DATA_WIDTH +: DATA_WIDTH];
         w_src_m[w] = bus.io_write_byteMask[w*NB +: NB];
         w_src_v[w] = bus.io_write_valid[w] && f_in_range(w_src_a[w]);
      end
      w_src_a[NUM_WRITE] = r_dst[ALU_LATENCY-1];
      w_src_d[NUM_WRITE] = r_res[ALU_LATENCY-1];
      w_src_m[NUM_WRITE] = r_mask[ALU_LATENCY-1];
      w_src_v[NUM_WRITE] = r_valid[ALU_LATENCY-1] && f_in_range(r_dst[ALU_LATENCY-1]);
   end

   // Array lookups with same-edge write bypass; later sources overwrite earlier ones so the
   // overlay order matches the commit priority.
   always_comb begin
      for (int unsigned p = 0; p < NUM_READ; p++) begin
         w_lk_a[p] = bus.io_read_address[p*AW +: AW];
      end
      w_lk_a[NUM_READ]   = bus.io_cmd_srcA;
      w_lk_a[NUM_READ+1] = bus.io_cmd_srcB;
      for (int unsigned k = 0; k < NLK; k++) begin
         w_lk_d[k] = '0;
         if (f_in_range(w_lk_a[k])) begin
            w_lk_d[k] = r_mem[w_lk_a[k]];
            for (int unsigned s = 0; s < NSRC; s++) begin
               if (w_src_v[s] && (w_src_a[s] == w_lk_a[k])) begin
                  for (int unsigned b = 0; b < NB; b++) begin
                     if (w_src_m[s][b]) w_lk_d[k][8*b +: 8] = w_src_d[s][8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Any two committing writes to the same address count, regardless of byte overlap.
   always_comb begin
      w_collide = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         for (int unsigned j = i + 1; j < NSRC; j++) begin
            if (w_src_v[i] && w_src_v[j] && (w_src_a[i] == w_src_a[j])) w_collide = 1'b1;
         end
      end
   end

   assign w_op_a = w_lk_d[NUM_READ];
   assign w_op_b = w_lk_d[NUM_READ+1];

   always_comb begin
      w_alu = w_op_a;
      case (bus.io_cmd_op)
         3'd0:    w_alu = w_op_a + w_op_b;
         3'd1:    w_alu = w_op_a - w_op_b;
         3'd2:    w_alu = w_op_a & w_op_b;
         3'd3:    w_alu = w_op_a | w_op_b;
         3'd4:    w_alu = w_op_a ^ w_op_b;
         3'd5:    w_alu = w_op_a << w_op_b[SHW-1:0];
         3'd6:    w_alu = w_op_a >> w_op_b[SHW-1:0];
         default: w_alu = w_op_a;
      endcase
   end

   // RAW interlock; the last stage writes back this edge and is bypassed, so it never stalls.
   always_comb begin
      w_ready = 1'b1;
      for (int unsigned st = 0; st + 1 < ALU_LATENCY; st++) begin
         if (r_valid[st] && ((r_dst[st] == bus.io_cmd_srcA) || (r_dst[st] == bus.io_cmd_srcB))) begin
            w_ready = 1'b0;
         end
      end
   end

   assign w_accept = bus.io_cmd_valid && w_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int unsigned st = 0; st < ALU_LATENCY; st++) begin
            r_dst[st]  <= '0;
            r_mask[st] <= '0;
            r_res[st]  <= '0;
         end
      end else begin
         r_valid[0] <= w_accept;
         r_dst[0]   <= bus.io_cmd_dst;
         r_mask[0]  <= bus.io_cmd_byteMask;
         r_res[0]   <= w_alu;
         for (int unsigned st = 1; st < ALU_LATENCY; st++) begin
            r_valid[st] <= r_valid[st-1];
            r_dst[st]   <= r_dst[st-1];
            r_mask[st]  <= r_mask[st-1];
            r_res[st]   <= r_res[st-1];
         end
      end
   end

   // Array is not reset; later loop iterations win, giving the ALU > high port > low port order.
   always_ff @(posedge clock) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
         if (w_src_v[s]) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (w_src_m[s][b]) r_mem[w_src_a[s]][8*b +: 8] <= w_src_d[s][8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_read_value <= '0;
         r_collisions <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_READ; p++) begin
            r_read_value[p*DATA_WIDTH +: DATA_WIDTH] <= w_lk_d[p];
         end
         if (w_collide && (r_collisions != 16'hFFFF)) r_collisions <= r_collisions + 16'd1;
      end
   end

   assign bus.io_read_value = r_read_value;
   assign bus.io_collisions = r_collisions;
   assign bus.io_cmd_ready  = w_ready;
   assign bus.io_busy       = |r_valid;
endmodule

// File: tb/tb_mock_alu_bypass_register_file.sv
// ---------------------------------------------------------------------------------------------
// tb_mock_alu_bypass_register_file
// Directed bench for mock_alu_bypass_register_file with default parameters (64-bit data,
// 128 entries, 4 read ports, 2 write ports, ALU latency 2). Inputs change and outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------------------------
module tb_mock_alu_bypass_register_file;
   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 128;
   localparam int unsigned NR    = 4;
   localparam int unsigned NW    = 2;
   localparam int unsigned LAT   = 2;
   localparam int unsigned AW    = 7;
   localparam int unsigned NB    = 8;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_PASS = 3'd7;

   // Streamed op table: sources are entries 1 (=7), 2 (=3), 5 (=0x11223344FFFFFFFF).
   localparam logic [2:0]    T_OP  [8] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SUB,
                                           OP_PASS, OP_PASS};
   localparam logic [AW-1:0] T_A   [8] = '{7'd1, 7'd1, 7'd1, 7'd1, 7'd5, 7'd2, 7'd1, 7'd1};
   localparam logic [AW-1:0] T_B   [8] = '{7'd2, 7'd2, 7'd2, 7'd2, 7'd2, 7'd1, 7'd2, 7'd2};
   localparam logic [AW-1:0] T_D   [8] = '{7'd6, 7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 7'd13, 7'd12};
   localparam logic [NB-1:0] T_M   [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                           8'h0F};
   localparam logic [63:0]   T_EXP [8] = '{64'h3, 64'h7, 64'h4, 64'h38, 64'h022446689FFFFFFF,
                                           64'hFFFFFFFFFFFFFFFC, 64'h7, 64'hFFFFFFFF00000007};

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   mock_alu_bypass_register_file_if #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW)
   ) bus ();

   mock_alu_bypass_register_file #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW), .ALU_LATENCY(LAT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int p, input logic v, input logic [AW-1:0] a, input logic [63:0] d,
                     input logic [NB-1:0] m);
      bus.io_write_valid[p]               = v;
      bus.io_write_address[p*AW +: AW]    = a;
      bus.io_write_value[p*DW +: DW]      = d;
      bus.io_write_byteMask[p*NB +: NB]   = m;
   endtask

   task automatic rd_addr(input int p, input logic [AW-1:0] a);
      bus.io_read_address[p*AW +: AW] = a;
   endtask

   function automatic logic [63:0] rd_val(input int p);
      return bus.io_read_value[p*DW +: DW];
   endfunction

   // Settles one time unit so io_cmd_ready can be sampled right after.
   task automatic cmd(input logic v, input logic [2:0] op, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [AW-1:0] d, input logic [NB-1:0] m);
      bus.io_cmd_valid    = v;
      bus.io_cmd_op       = op;
      bus.io_cmd_srcA     = a;
      bus.io_cmd_srcB     = b;
      bus.io_cmd_dst      = d;
      bus.io_cmd_byteMask = m;
      #1;
   endtask

   initial begin
      bus.io_read_address   = '0;
      bus.io_write_valid    = '0;
      bus.io_write_address  = '0;
      bus.io_write_value    = '0;
      bus.io_write_byteMask = '0;
      bus.io_cmd_valid      = 1'b0;
      bus.io_cmd_op         = '0;
      bus.io_cmd_srcA       = '0;
      bus.io_cmd_srcB       = '0;
      bus.io_cmd_dst        = '0;
      bus.io_cmd_byteMask   = '0;

      // Reset state
      #12;
      check("reset_rd0", rd_val(0), 64'h0);
      check("reset_rd3", rd_val(3), 64'h0);
      check("reset_busy", 64'(bus.io_busy), 64'h0);
      check("reset_coll", 64'(bus.io_collisions), 64'h0);
      reset = 1'b1;

      // Zero entries 0..31, two distinct addresses per edge
      for (int i = 0; i < 32; i += 2) begin
         wr(0, 1'b1, AW'(i), 64'h0, 8'hFF);
         wr(1, 1'b1, AW'(i + 1), 64'h0, 8'hFF);
         tick();
      end
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      check("init_no_coll", 64'(bus.io_collisions), 64'h0);

      // Same-edge write-to-read bypass, full then partial mask
      wr(0, 1'b1, 7'd5, 64'h1122334455667788, 8'hFF);
      rd_addr(0, 7'd5);
      tick();
      check("rd_bypass_full", rd_val(0), 64'h1122334455667788);
      wr(0, 1'b1, 7'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      tick();
      check("rd_bypass_mask", rd_val(0), 64'h11223344FFFFFFFF);
      wr(0, 1'b0, '0, '0, '0);
      rd_addr(1, 7'd5);
      tick();
      check("rd_stored", rd_val(1), 64'h11223344FFFFFFFF);

      // Highest address
      wr(1, 1'b1, 7'd127, 64'hCAFEF00D12345678, 8'hFF);
      tick();
      wr(1, 1'b0, '0, '0, '0);
      rd_addr(2, 7'd127);
      tick();
      check("rd_addr127", rd_val(2), 64'hCAFEF00D12345678);

      // SUB 7-3 into entry 3, exact latency and busy window
      wr(0, 1'b1, 7'd1, 64'd7, 8'hFF);
      wr(1, 1'b1, 7'd2, 64'd3, 8'hFF);
      tick();
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      rd_addr(2, 7'd3);
      cmd(1'b1, OP_SUB, 7'd1, 7'd2, 7'd3, 8'hFF);
      check("ready_idle", 64'(bus.io_cmd_ready), 64'h1);
      tick();
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      check("sub_busy_e1", 64'(bus.io_busy), 64'h1);
      check("sub_rd_e1", rd_val(2), 64'h0);
      tick();
      check("sub_busy_e2", 64'(bus.io_busy), 64'h1);
      check("sub_rd_e2", rd_val(2), 64'h0);
      tick();
      check("sub_busy_done", 64'(bus.io_busy), 64'h0);
      check("sub_result", rd_val(2), 64'd4);

      // RAW interlock: ADD 7+3 -> e3, then ADD e3+e1 -> e4
      cmd(1'b1, OP_ADD, 7'd1, 7'd2, 7'd3, 8'hFF);
      tick();
      cmd(1'b1, OP_ADD, 7'd3, 7'd1, 7'd4, 8'hFF);
      check("raw_stall", 64'(bus.io_cmd_ready), 64'h0);
      tick();
      check("raw_wb_no_stall", 64'(bus.io_cmd_ready), 64'h1);
      tick();
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      check("raw_busy", 64'(bus.io_busy), 64'h1);
      rd_addr(0, 7'd4);
      rd_addr(1, 7'd3);
      tick();
      check("raw_e4_before", rd_val(0), 64'h0);
      check("raw_e3", rd_val(1), 64'd10);
      tick();
      check("raw_e4_after", rd_val(0), 64'd17);

      // One op per cycle through every opcode, then read all destinations
      wr(0, 1'b1, 7'd12, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      tick();
      wr(0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 8; i++) begin
         cmd(1'b1, T_OP[i], T_A[i], T_B[i], T_D[i], T_M[i]);
         check($sformatf("stream_ready_%0d", i), 64'(bus.io_cmd_ready), 64'h1);
         tick();
      end
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      tick();
      tick();
      for (int g = 0; g < 2; g++) begin
         for (int p = 0; p < 4; p++) rd_addr(p, T_D[g*4 + p]);
         tick();
         for (int p = 0; p < 4; p++) begin
            check($sformatf("op_result_%0d", g*4 + p), rd_val(p), T_EXP[g*4 + p]);
         end
      end

      // ALU writeback beats both external ports on the same entry and edge
      cmd(1'b1, OP_PASS, 7'd1, 7'd2, 7'd14, 8'hFF);
      tick();
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      tick();
      wr(0, 1'b1, 7'd14, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      wr(1, 1'b1, 7'd14, 64'hBBBBBBBBBBBBBBBB, 8'hFF);
      rd_addr(3, 7'd14);
      tick();
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      check("alu_wins_bypass", rd_val(3), 64'd7);
      check("coll_alu_ext", 64'(bus.io_collisions), 64'd1);
      tick();
      check("alu_wins_stored", rd_val(3), 64'd7);
      check("coll_quiet", 64'(bus.io_collisions), 64'd1);

      // Port 1 beats port 0, per byte
      rd_addr(0, 7'd9);
      wr(0, 1'b1, 7'd9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      wr(1, 1'b1, 7'd9, 64'hBBBBBBBBBBBBBBBB, 8'hFF);
      tick();
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      tick();
      check("port_prio", rd_val(0), 64'hBBBBBBBBBBBBBBBB);
      check("coll_two", 64'(bus.io_collisions), 64'd2);
      wr(0, 1'b1, 7'd9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      wr(1, 1'b1, 7'd9, 64'hBBBBBBBBBBBBBBBB, 8'h0F);
      tick();
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      tick();
      check("port_prio_bytes", rd_val(0), 64'hAAAAAAAABBBBBBBB);
      check("coll_three", 64'(bus.io_collisions), 64'd3);

      // 70000 colliding edges: exact count mid-way, then saturation
      wr(0, 1'b1, 7'd9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      wr(1, 1'b1, 7'd9, 64'hBBBBBBBBBBBBBBBB, 8'hFF);
      repeat (100) @(posedge clock);
      #1;
      check("coll_count", 64'(bus.io_collisions), 64'd103);
      repeat (69900) @(posedge clock);
      #1;
      check("coll_saturate", 64'(bus.io_collisions), 64'hFFFF);
      wr(0, 1'b0, '0, '0, '0);
      wr(1, 1'b0, '0, '0, '0);
      tick();
      check("coll_hold", 64'(bus.io_collisions), 64'hFFFF);

      // Reset with two ops in flight
      cmd(1'b1, OP_PASS, 7'd1, 7'd2, 7'd15, 8'hFF);
      tick();
      cmd(1'b1, OP_PASS, 7'd2, 7'd1, 7'd0, 8'hFF);
      tick();
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      check("inflight_busy", 64'(bus.io_busy), 64'h1);
      reset = 1'b0;
      #1;
      check("rst_busy", 64'(bus.io_busy), 64'h0);
      check("rst_rd", rd_val(0), 64'h0);
      check("rst_coll", 64'(bus.io_collisions), 64'h0);
      check("rst_ready", 64'(bus.io_cmd_ready), 64'h1);
      @(posedge clock);
      @(posedge clock);
      #4;
      reset = 1'b1;

      // First command accepted on the first edge after release
      cmd(1'b1, OP_ADD, 7'd1, 7'd2, 7'd16, 8'hFF);
      check("post_rst_ready", 64'(bus.io_cmd_ready), 64'h1);
      tick();
      cmd(1'b0, OP_ADD, '0, '0, '0, '0);
      check("post_rst_busy", 64'(bus.io_busy), 64'h1);
      tick();
      tick();
      rd_addr(0, 7'd15);
      rd_addr(1, 7'd0);
      rd_addr(2, 7'd16);
      tick();
      check("discard_e15", rd_val(0), 64'h0);
      check("discard_e0", rd_val(1), 64'h0);
      check("post_rst_add", rd_val(2), 64'd10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
